rom_ctrl_kmac_packer: RTL
=========================

# rom_ctrl_kmac_packer

Width adapter between the ROM checker FSM's KMAC ROM-data port and the KMAC application interface. It accepts ROM words one at a time under a valid/ready handshake, packs them little-endian into KMAC message beats of `OutW` bits, and flags each beat's valid bytes with a strobe. When the FSM's `last` word arrives it flushes a partial beat, then locks. Any further input after the message ends raises a sticky error, which the FSM folds into its alert.

## Interface
- `InW`, default 32: ROM data word width; must be a multiple of 8.
- `OutW`, default 64: KMAC beat width; must be a multiple of `InW`. N = OutW/InW ≥ 1.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `in_valid_i` input 1: ROM word valid (FSM `kmac_rom_vld_o`).
- `in_data_i` input InW: ROM word.
- `in_last_i` input 1: final word of message (FSM `kmac_rom_last_o`).
- `in_ready_o` output 1: word accepted this cycle when high with `in_valid_i` (to FSM `kmac_rom_rdy_i`).
- `out_valid_o` output 1: beat valid to KMAC.
- `out_data_o` output OutW: packed beat.
- `out_strb_o` output OutW/8: byte strobes for `out_data_o`.
- `out_last_o` output 1: final beat of message.
- `out_ready_i` input 1: KMAC accepts beat.
- `done_o` output 1: final beat handshaken; stays high until reset.
- `err_o` output 1: sticky protocol error.

## Operation
- Storage:
  - Accumulator of N−1 words.
  - Word counter `cnt`, width vbits(N), range 0..N−1.
  - One output register holding data, strb, last and valid.
  - State register with states Fill, Drain and Done.
- Input acceptance: `in_ready_o = (state==Fill) && (!out_valid_o || out_ready_i)`. Accept means `in_valid_i && in_ready_o`.
- Packing: word k of a beat occupies bits [k·InW +: InW], with the first-accepted word in the LSBs.
- On accept with `cnt < N−1` and `!in_last_i`:
  - Store the word in accumulator slot `cnt`.
  - Increment `cnt`.
- On accept with `cnt == N−1` or `in_last_i`:
  - Load the output register with the accumulator plus the incoming word in slot `cnt`. Slots above `cnt` are zero.
  - Set strb to ones for bytes 0..((cnt+1)·InW/8 − 1) and zero elsewhere.
  - Copy `in_last_i` into `out_last_o` and set valid.
  - Reset `cnt` to 0 and clear the accumulator.
- Output handshake: when `out_valid_o && out_ready_i`, valid clears unless a new beat loads in the same cycle. Data, strb and last stay stable while valid and not ready.
- State transitions:
  - Fill → Drain on accepting a word with `in_last_i`.
  - Drain → Done on output handshake with `out_last_o`.
  - Done is terminal.
- `done_o = (state==Done)`.
- `err_o` is set and held when `in_valid_i` is high in Drain or Done. Offending input is dropped and `in_ready_o` stays 0.
- N == 1 is a pure register slice: every accepted word forms a full beat.

## Timing
- Reset values:
  - `in_ready_o`=1 (Fill, output empty).
  - `out_valid_o`=0, `out_data_o`=0, `out_strb_o`=0, `out_last_o`=0.
  - `done_o`=0, `err_o`=0.
  - `cnt`=0, accumulator=0.
- Reset mid-message discards all partial state on that edge. There is no output beat for the partial data.
- Latency: a beat appears on `out_*` the cycle after its completing word is accepted.
- Throughput: with `out_ready_i` held at 1, one word is accepted every cycle and one beat is produced every N cycles.
- Simultaneous handshake: output handshake and new beat load in the same cycle are allowed and produce back-to-back beats with no bubble.
- Backpressure: a full output register with `out_ready_i`=0 drops `in_ready_o` combinationally. The partially filled accumulator holds.
- `done_o` rises the cycle after the last-beat handshake.
- `err_o` rises the cycle after the offending `in_valid_i`.

## Test plan
- InW=32, OutW=64, `out_ready_i`=1:
  - Feed 0x11111111 then 0x22222222 with last on the second word.
  - Expect one beat, one cycle later: data 0x22222222_11111111, strb 0xFF, last=1.
  - Expect `done_o`=1 the following cycle.
- Odd count: feed A=0xAAAAAAAA, B=0xBBBBBBBB, C=0xCCCCCCCC with last on C.
  - Expect beat {B,A}, strb 0xFF, last=0.
  - Expect beat 0x00000000_CCCCCCCC, strb 0x0F, last=1.
- Backpressure:
  - Hold `out_ready_i`=0 for 5 cycles with the output full and `in_valid_i`=1. Expect `in_ready_o`=0 and `out_data_o` stable.
  - Release `out_ready_i`. Expect the stream to continue with no word lost or duplicated.
- Error: after `done_o`=1, drive `in_valid_i`=1 for 1 cycle.
  - Expect `err_o`=1 from the next cycle, holding while idle.
  - Expect `in_ready_o`=0 and no output beat.
- Reset mid-message:
  - Accept 0xDEADBEEF, then pulse `rst_i` for 1 cycle. Expect all outputs at reset values.
  - Feed 0x1, 0x2 (last). Expect a single beat 0x00000002_00000001 with no stale data.
- Streaming: feed 8 words 0..7 back-to-back with last on word 7 and `out_ready_i`=1.
  - Expect 4 beats, one every 2 cycles, each with strb 0xFF.
  - Expect last only on the fourth beat and `in_ready_o` never low before the last word.

Source files
------------

// File: rtl/rom_ctrl_kmac_packer_if.sv
// rtl/rom_ctrl_kmac_packer_if.sv - ROM word input and KMAC beat output handshake bundle
interface rom_ctrl_kmac_packer_if #(
  parameter int InW  = 32,
  parameter int OutW = 64
);
  logic              in_valid_i;
  logic [InW-1:0]    in_data_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [OutW-1:0]   out_data_o;
  logic [OutW/8-1:0] out_strb_o;
  logic              out_last_o;
  logic              out_ready_i;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, done_o, err_o
  );

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o, done_o, err_o
  );
endinterface

// File: rtl/rom_ctrl_kmac_packer.sv
// rtl/rom_ctrl_kmac_packer.sv - packs ROM words little-endian into strobed KMAC beats
module rom_ctrl_kmac_packer #(
  parameter int InW  = 32,
  parameter int OutW = 64
) (
  input logic                   clk_i,
  input logic                   rst_i,
  rom_ctrl_kmac_packer_if.slave bus
);
  localparam int N    = OutW / InW;
  localparam int CntW = (N > 1) ? $clog2(N) : 1;
  localparam int AccW = (N > 1) ? (N - 1) * InW : InW;
  localparam int InB  = InW / 8;
  localparam int OutB = OutW / 8;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [AccW-1:0] acc_q;
  logic [OutW-1:0] acc_ext;
  logic            out_valid_q;
  logic            out_last_q;
  logic [OutW-1:0] out_data_q;
  logic [OutB-1:0] out_strb_q;
  logic            err_q;

  logic            in_ready;
  logic            accept;
  logic            at_top;
  logic            complete;
  logic            out_hs;
  logic [OutW-1:0] beat_data;
  logic [OutB-1:0] beat_strb;

  assign in_ready = (state_q == StFill) && (!out_valid_q || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;
  assign at_top   = (int'(cnt_q) == N - 1);
  assign complete = accept && (at_top || bus.in_last_i);
  assign out_hs   = out_valid_q && bus.out_ready_i;
  assign acc_ext  = OutW'(acc_q);

  // Slots below cnt come from the accumulator, slot cnt is the live word, the rest stay zero.
  always_comb begin
    beat_data = '0;
    beat_strb = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt_q)) begin
        beat_data[k*InW +: InW] = acc_ext[k*InW +: InW];
      end else if (k == int'(cnt_q)) begin
        beat_data[k*InW +: InW] = bus.in_data_i;
      end
      if (k <= int'(cnt_q)) begin
        beat_strb[k*InB +: InB] = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || complete) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  generate
    if (N > 1) begin : g_acc
      always_ff @(posedge clk_i) begin
        if (rst_i || complete) begin
          acc_q <= '0;
        end else if (accept) begin
          acc_q[int'(cnt_q)*InW +: InW] <= bus.in_data_i;
        end
      end
    end else begin : g_no_acc
      // A single-word beat never needs to hold partial data.
      assign acc_q = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= beat_data;
      out_strb_q  <= beat_strb;
      out_last_q  <= bus.in_last_i;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Any word offered once the message has ended is a protocol violation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (bus.in_valid_i && (state_q != StFill)) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill: begin
        if (accept && bus.in_last_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_hs && out_last_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StFill;
    endcase
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_strb_o  = out_strb_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_o       = err_q;
endmodule
